// File: rtl/mem_ctrl_pkg.sv
// Shared widths, access-size encodings and FSM state type for the memory controller.
package mem_ctrl_pkg;

  localparam int ADDR    = 32;
  localparam int DATALEN = 32;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  typedef enum logic [1:0] {
    IDLE,
    READ,
    WRITE
  } state_e;

  // Number of bytes moved for an LSB access size.
  function automatic logic [2:0] sizeLen(input logic [1:0] size);
    case (size)
      SIZE_BYTE: return 3'd1;
      SIZE_HALF: return 3'd2;
      SIZE_WORD: return 3'd4;
      default:   return 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/mem_ctrl.sv
// Byte-serial RAM controller arbitrating instruction fetches and LSB loads/stores,
// with I/O store back-pressure, ROB flush of reads and a global rdy freeze.
module mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter logic [1:0] IO_HI = 2'b11
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               rdy,
  input  logic               clear,
  input  logic [7:0]         mem_din,
  output logic [7:0]         mem_dout,
  output logic [ADDR-1:0]    mem_a,
  output logic               mem_wr,
  input  logic               io_buffer_full,
  input  logic               if_req,
  input  logic [ADDR-1:0]    if_addr,
  output logic               if_done,
  output logic [DATALEN-1:0] if_data,
  input  logic               ls_req,
  input  logic               ls_wr,
  input  logic [ADDR-1:0]    ls_addr,
  input  logic [1:0]         ls_size,
  input  logic [DATALEN-1:0] ls_wdata,
  output logic               ls_done,
  output logic [DATALEN-1:0] ls_rdata
);

  state_e             state_q;
  logic [2:0]         cnt_q;
  logic [2:0]         len_q;
  logic               isLs_q;
  logic [ADDR-1:0]    addr_q;
  logic [DATALEN-1:0] wdata_q;
  logic [DATALEN-1:0] rdBuf_q;
  logic [ADDR-1:0]    memAddr_q;
  logic [7:0]         memDout_q;
  logic               memWr_q;
  logic               ifDone_q;
  logic [DATALEN-1:0] ifData_q;
  logic               lsDone_q;
  logic [DATALEN-1:0] lsRdata_q;

  logic [2:0]         cntInc_d;
  logic [ADDR-1:0]    byteAddr_d;
  logic [ADDR-1:0]    nextAddr_d;
  logic [7:0]         wrByte_d;
  logic [1:0]         capIdx_d;
  logic [DATALEN-1:0] rdMerged_d;
  logic               ioBlocked;
  logic               acceptIoBlocked;

  // In READ, cnt_q-1 is the byte arriving on mem_din this cycle.
  always_comb begin
    cntInc_d   = cnt_q + 3'd1;
    byteAddr_d = addr_q + ADDR'(cnt_q);
    nextAddr_d = addr_q + ADDR'(cntInc_d);
    wrByte_d   = wdata_q[{cnt_q[1:0], 3'b000} +: 8];
    capIdx_d   = cnt_q[1:0] - 2'd1;
    rdMerged_d = rdBuf_q;
    rdMerged_d[{capIdx_d, 3'b000} +: 8] = mem_din;
  end

  assign ioBlocked       = (addr_q[17:16] == IO_HI) && io_buffer_full;
  assign acceptIoBlocked = (ls_addr[17:16] == IO_HI) && io_buffer_full;

  // A requester whose done pulse is still up is not re-accepted; its req drops next edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      len_q     <= '0;
      isLs_q    <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      rdBuf_q   <= '0;
      memAddr_q <= '0;
      memDout_q <= '0;
      memWr_q   <= 1'b0;
      ifDone_q  <= 1'b0;
      ifData_q  <= '0;
      lsDone_q  <= 1'b0;
      lsRdata_q <= '0;
    end else if (rdy) begin
      ifDone_q <= 1'b0;
      lsDone_q <= 1'b0;
      case (state_q)
        IDLE: begin
          cnt_q     <= '0;
          rdBuf_q   <= '0;
          memAddr_q <= '0;
          memDout_q <= '0;
          memWr_q   <= 1'b0;
          if (!clear) begin
            if (ls_req && !lsDone_q) begin
              isLs_q    <= 1'b1;
              addr_q    <= ls_addr;
              wdata_q   <= ls_wdata;
              len_q     <= sizeLen(ls_size);
              memAddr_q <= ls_addr;
              if (ls_wr) begin
                state_q <= WRITE;
                if (!acceptIoBlocked) begin
                  memDout_q <= ls_wdata[7:0];
                  memWr_q   <= 1'b1;
                  cnt_q     <= 3'd1;
                end
              end else begin
                state_q <= READ;
              end
            end else if (if_req && !ifDone_q) begin
              isLs_q    <= 1'b0;
              addr_q    <= if_addr;
              len_q     <= 3'd4;
              memAddr_q <= if_addr;
              state_q   <= READ;
            end
          end
        end
        READ: begin
          if (clear) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            memAddr_q <= '0;
          end else begin
            if (cnt_q != 3'd0) rdBuf_q <= rdMerged_d;
            if (cnt_q == len_q) begin
              state_q   <= IDLE;
              cnt_q     <= '0;
              memAddr_q <= '0;
              if (isLs_q) begin
                lsDone_q  <= 1'b1;
                lsRdata_q <= rdMerged_d;
              end else begin
                ifDone_q <= 1'b1;
                ifData_q <= rdMerged_d;
              end
            end else begin
              cnt_q <= cntInc_d;
              if (cntInc_d < len_q) memAddr_q <= nextAddr_d;
            end
          end
        end
        WRITE: begin
          if (cnt_q == len_q) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            memAddr_q <= '0;
            memDout_q <= '0;
            memWr_q   <= 1'b0;
            lsDone_q  <= 1'b1;
          end else if (ioBlocked) begin
            memWr_q <= 1'b0;
          end else begin
            memAddr_q <= byteAddr_d;
            memDout_q <= wrByte_d;
            memWr_q   <= 1'b1;
            cnt_q     <= cntInc_d;
          end
        end
        default: begin
          state_q <= IDLE;
          cnt_q   <= '0;
          memWr_q <= 1'b0;
        end
      endcase
    end
  end

  assign mem_a    = memAddr_q;
  assign mem_dout = memDout_q;
  assign mem_wr   = memWr_q & rdy;
  assign if_done  = ifDone_q;
  assign if_data  = ifData_q;
  assign ls_done  = lsDone_q;
  assign ls_rdata = lsRdata_q;

endmodule

// File: tb/tb_mem_ctrl.sv
// Self-checking bench for mem_ctrl: directed scenarios plus randomized traffic
// checked against a byte-array model of memory.
module tb_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst, rdy, clear, io_buffer_full;
  logic [7:0]  mem_din, mem_dout;
  logic [31:0] mem_a;
  logic        mem_wr;
  logic        if_req, if_done;
  logic [31:0] if_addr, if_data;
  logic        ls_req, ls_wr, ls_done;
  logic [31:0] ls_addr, ls_wdata, ls_rdata;
  logic [1:0]  ls_size;

  int checks = 0;
  int errors = 0;

  bit   [7:0]  ram   [0:131071];
  bit   [7:0]  model [0:131071];
  logic        preEn;
  logic [16:0] preAddr;
  logic [7:0]  preData;
  logic [31:0] wA [0:1023];
  logic [7:0]  wD [0:1023];
  int          wCount = 0;

  mem_ctrl #(.IO_HI(2'b11)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .clear(clear),
    .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
    .io_buffer_full(io_buffer_full),
    .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_data(if_data),
    .ls_req(ls_req), .ls_wr(ls_wr), .ls_addr(ls_addr), .ls_size(ls_size),
    .ls_wdata(ls_wdata), .ls_done(ls_done), .ls_rdata(ls_rdata)
  );

  always #5 clk = ~clk;

  // RAM with one-cycle read latency; logs every byte actually written.
  always @(posedge clk) begin
    mem_din <= ram[mem_a[16:0]];
    if (preEn) ram[preAddr] <= preData;
    else if (mem_wr) begin
      ram[mem_a[16:0]] <= mem_dout;
      wA[wCount] <= mem_a;
      wD[wCount] <= mem_dout;
      wCount <= wCount + 1;
    end
  end

  task automatic preload(input logic [16:0] a, input logic [7:0] d);
    preEn = 1'b1; preAddr = a; preData = d;
    @(negedge clk);
    preEn = 1'b0;
  endtask

  task automatic doXfer(input bit isIf, input bit wr, input logic [31:0] addr, input logic [1:0] size,
                        input logic [31:0] wdata, output int lat, output logic [31:0] rdata);
    if (isIf) begin
      if_req = 1'b1; if_addr = addr;
    end else begin
      ls_req = 1'b1; ls_wr = wr; ls_addr = addr; ls_size = size; ls_wdata = wdata;
    end
    lat = -1; rdata = '0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (isIf ? if_done : ls_done) begin
        lat = k; rdata = isIf ? if_data : ls_rdata;
        break;
      end
    end
    if_req = 1'b0; ls_req = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; if_req = 1'b1; ls_req = 1'b1; ls_addr = 32'h1234; if_addr = 32'h5678;
    repeat (2) @(negedge clk);
    checks++; if (mem_a !== 32'h0) begin errors++; $display("[TB] FAIL reset_mem_a: got %h expected 0", mem_a); end
    checks++; if (mem_wr !== 1'b0) begin errors++; $display("[TB] FAIL reset_mem_wr: got %b expected 0", mem_wr); end
    checks++; if (mem_dout !== 8'h0) begin errors++; $display("[TB] FAIL reset_mem_dout: got %h expected 0", mem_dout); end
    checks++; if (if_done !== 1'b0) begin errors++; $display("[TB] FAIL reset_if_done: got %b expected 0", if_done); end
    checks++; if (ls_done !== 1'b0) begin errors++; $display("[TB] FAIL reset_ls_done: got %b expected 0", ls_done); end
    if_req = 1'b0; ls_req = 1'b0; rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_fetch();
    int doneK = -1, doneCnt = 0;
    logic [31:0] got = '0;
    preload(17'h104, 8'h13); preload(17'h105, 8'h05); preload(17'h106, 8'h00); preload(17'h107, 8'h00);
    if_req = 1'b1; if_addr = 32'h104;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (k <= 4) begin
        checks++; if (mem_a !== 32'h104 + 32'(k - 1)) begin errors++; $display("[TB] FAIL fetch_addr%0d: got %h expected %h", k, mem_a, 32'h104 + 32'(k - 1)); end
      end
      if (if_done) begin
        doneCnt++;
        if (doneK < 0) begin doneK = k; got = if_data; if_req = 1'b0; end
      end
    end
    checks++; if (doneK !== 6) begin errors++; $display("[TB] FAIL fetch_latency: got %0d expected 6", doneK); end
    checks++; if (got !== 32'h00000513) begin errors++; $display("[TB] FAIL fetch_data: got %h expected 00000513", got); end
    checks++; if (doneCnt !== 1) begin errors++; $display("[TB] FAIL fetch_done_pulses: got %0d expected 1", doneCnt); end
  endtask

  task automatic test_priority();
    logic [7:0] b [4];
    logic [31:0] expWord;
    int lsK = -1, ifK = -1, lsCnt = 0, ifCnt = 0;
    logic [31:0] lsData = '0, ifData = '0;
    preload(17'h200, 8'h8F);
    for (int i = 0; i < 4; i++) begin
      b[i] = 8'($urandom);
      preload(17'h300 + 17'(i), b[i]);
    end
    expWord = {b[3], b[2], b[1], b[0]};
    if_req = 1'b1; if_addr = 32'h300;
    ls_req = 1'b1; ls_wr = 1'b0; ls_addr = 32'h200; ls_size = 2'b00;
    for (int k = 1; k <= 14; k++) begin
      @(negedge clk);
      if (ls_done) begin lsCnt++; lsK = k; lsData = ls_rdata; ls_req = 1'b0; end
      if (if_done) begin ifCnt++; ifK = k; ifData = if_data; if_req = 1'b0; end
    end
    checks++; if (lsK !== 3) begin errors++; $display("[TB] FAIL prio_ls_latency: got %0d expected 3", lsK); end
    checks++; if (lsData !== 32'h0000008F) begin errors++; $display("[TB] FAIL prio_ls_data: got %h expected 0000008f", lsData); end
    checks++; if (ifK !== 9) begin errors++; $display("[TB] FAIL prio_if_latency: got %0d expected 9", ifK); end
    checks++; if (ifData !== expWord) begin errors++; $display("[TB] FAIL prio_if_data: got %h expected %h", ifData, expWord); end
    checks++; if (lsCnt !== 1 || ifCnt !== 1) begin errors++; $display("[TB] FAIL prio_pulses: got ls=%0d if=%0d expected 1 each", lsCnt, ifCnt); end
  endtask

  task automatic test_half_store();
    int lat, start;
    logic [31:0] rd;
    start = wCount;
    doXfer(1'b0, 1'b1, 32'h1000, 2'b01, 32'h0000BEEF, lat, rd);
    checks++; if (lat !== 3) begin errors++; $display("[TB] FAIL half_latency: got %0d expected 3", lat); end
    checks++; if (wCount - start !== 2) begin errors++; $display("[TB] FAIL half_writes: got %0d expected 2", wCount - start); end
    checks++; if (wA[start] !== 32'h1000 || wD[start] !== 8'hEF) begin errors++; $display("[TB] FAIL half_byte0: got %h=%h expected 00001000=ef", wA[start], wD[start]); end
    checks++; if (wA[start+1] !== 32'h1001 || wD[start+1] !== 8'hBE) begin errors++; $display("[TB] FAIL half_byte1: got %h=%h expected 00001001=be", wA[start+1], wD[start+1]); end
  endtask

  task automatic test_io_store();
    int start = wCount, doneK = -1;
    io_buffer_full = 1'b1;
    ls_req = 1'b1; ls_wr = 1'b1; ls_addr = 32'h30000; ls_size = 2'b00; ls_wdata = 32'h41;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (k <= 3) begin
        checks++; if (mem_wr !== 1'b0) begin errors++; $display("[TB] FAIL io_hold%0d: got mem_wr %b expected 0", k, mem_wr); end
      end
      if (k == 4) begin
        checks++; if (mem_wr !== 1'b1) begin errors++; $display("[TB] FAIL io_issue: got mem_wr %b expected 1", mem_wr); end
      end
      if (k == 3) io_buffer_full = 1'b0;
      if (ls_done && doneK < 0) begin doneK = k; ls_req = 1'b0; end
    end
    checks++; if (doneK !== 5) begin errors++; $display("[TB] FAIL io_latency: got %0d expected 5", doneK); end
    checks++; if (wCount - start !== 1 || wA[start] !== 32'h30000 || wD[start] !== 8'h41) begin errors++; $display("[TB] FAIL io_write: got %0d writes first %h=%h expected 1 write 00030000=41", wCount - start, wA[start], wD[start]); end
  endtask

  task automatic test_clear();
    int doneCnt = 0, doneK = -1, start;
    logic [31:0] wdata = $urandom;
    ls_req = 1'b1; ls_wr = 1'b0; ls_addr = 32'h400; ls_size = 2'b10;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (ls_done) doneCnt++;
      if (k == 3) begin clear = 1'b1; ls_req = 1'b0; end
      if (k == 4) begin
        checks++; if (mem_a !== 32'h0) begin errors++; $display("[TB] FAIL clear_load_idle: got mem_a %h expected 0", mem_a); end
        clear = 1'b0;
      end
    end
    checks++; if (doneCnt !== 0) begin errors++; $display("[TB] FAIL clear_load_done: got %0d pulses expected 0", doneCnt); end
    start = wCount;
    ls_req = 1'b1; ls_wr = 1'b1; ls_addr = 32'h3000; ls_size = 2'b10; ls_wdata = wdata;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      clear = (k == 2);
      if (ls_done && doneK < 0) begin doneK = k; ls_req = 1'b0; end
    end
    checks++; if (doneK !== 5) begin errors++; $display("[TB] FAIL clear_store_latency: got %0d expected 5", doneK); end
    checks++; if (wCount - start !== 4) begin errors++; $display("[TB] FAIL clear_store_writes: got %0d expected 4", wCount - start); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (wA[start+i] !== 32'h3000 + 32'(i) || wD[start+i] !== wdata[8*i +: 8]) begin errors++; $display("[TB] FAIL clear_store_byte%0d: got %h=%h expected %h=%h", i, wA[start+i], wD[start+i], 32'h3000 + 32'(i), wdata[8*i +: 8]); end
    end
  endtask

  task automatic test_rdy_stall();
    int doneK = -1, start = wCount;
    logic [31:0] wdata = $urandom;
    ls_req = 1'b1; ls_wr = 1'b1; ls_addr = 32'h2000; ls_size = 2'b10; ls_wdata = wdata;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (k == 3) begin
        checks++; if (mem_wr !== 1'b0) begin errors++; $display("[TB] FAIL stall_wr_gated: got %b expected 0", mem_wr); end
      end
      if (k == 2) rdy = 1'b0;
      if (k == 4) rdy = 1'b1;
      if (ls_done && doneK < 0) begin doneK = k; ls_req = 1'b0; end
    end
    checks++; if (doneK !== 7) begin errors++; $display("[TB] FAIL stall_latency: got %0d expected 7", doneK); end
    checks++; if (wCount - start !== 4) begin errors++; $display("[TB] FAIL stall_writes: got %0d expected 4", wCount - start); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (wA[start+i] !== 32'h2000 + 32'(i) || wD[start+i] !== wdata[8*i +: 8]) begin errors++; $display("[TB] FAIL stall_byte%0d: got %h=%h expected %h=%h", i, wA[start+i], wD[start+i], 32'h2000 + 32'(i), wdata[8*i +: 8]); end
    end
  endtask

  task automatic test_reset_mid_read();
    int doneCnt = 0;
    ls_req = 1'b1; ls_wr = 1'b0; ls_addr = 32'h104; ls_size = 2'b10;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (ls_done) doneCnt++;
      if (k == 4) begin
        checks++; if (mem_a !== 32'h0 || mem_wr !== 1'b0 || mem_dout !== 8'h0) begin errors++; $display("[TB] FAIL rst_read_mem: got a=%h wr=%b dout=%h expected all 0", mem_a, mem_wr, mem_dout); end
        checks++; if (ls_rdata !== 32'h0 || if_data !== 32'h0) begin errors++; $display("[TB] FAIL rst_read_data: got ls=%h if=%h expected 0", ls_rdata, if_data); end
        rst = 1'b0;
      end
      if (k == 3) begin rst = 1'b1; ls_req = 1'b0; end
    end
    checks++; if (doneCnt !== 0) begin errors++; $display("[TB] FAIL rst_read_done: got %0d pulses expected 0", doneCnt); end
  endtask

  task automatic test_random();
    for (int op = 0; op < 60; op++) begin
      int kind = $urandom_range(0, 2);
      logic [1:0] size = (kind == 0) ? 2'b10 : 2'($urandom_range(0, 2));
      int n = (size == 2'b00) ? 1 : (size == 2'b01) ? 2 : 4;
      logic [31:0] addr = ($urandom_range(0, 5) == 0) ? 32'hFFFFFFF8 + 32'($urandom_range(0, 7))
                                                      : 32'h8000 + 32'($urandom_range(0, 63));
      logic [31:0] wdata = $urandom;
      logic [31:0] expData = '0;
      logic [31:0] rd, a;
      int lat, start = wCount;
      if (kind == 2) begin
        doXfer(1'b0, 1'b1, addr, size, wdata, lat, rd);
        checks++; if (lat !== n + 1) begin errors++; $display("[TB] FAIL rnd%0d_store_latency: got %0d expected %0d", op, lat, n + 1); end
        checks++; if (wCount - start !== n) begin errors++; $display("[TB] FAIL rnd%0d_store_count: got %0d expected %0d", op, wCount - start, n); end
        for (int i = 0; i < n; i++) begin
          a = addr + 32'(i);
          checks++; if (wA[start+i] !== a || wD[start+i] !== wdata[8*i +: 8]) begin errors++; $display("[TB] FAIL rnd%0d_store_byte%0d: got %h=%h expected %h=%h", op, i, wA[start+i], wD[start+i], a, wdata[8*i +: 8]); end
          model[a[16:0]] = wdata[8*i +: 8];
        end
      end else begin
        for (int i = 0; i < n; i++) begin
          a = addr + 32'(i);
          expData[8*i +: 8] = model[a[16:0]];
        end
        doXfer(kind == 0, 1'b0, addr, size, 32'h0, lat, rd);
        checks++; if (lat !== n + 2) begin errors++; $display("[TB] FAIL rnd%0d_read_latency: got %0d expected %0d", op, lat, n + 2); end
        checks++; if (rd !== expData) begin errors++; $display("[TB] FAIL rnd%0d_read_data: got %h expected %h", op, rd, expData); end
      end
    end
  endtask

  initial begin
    rst = 1'b1; rdy = 1'b1; clear = 1'b0; io_buffer_full = 1'b0;
    if_req = 1'b0; if_addr = '0; ls_req = 1'b0; ls_wr = 1'b0; ls_addr = '0; ls_size = '0; ls_wdata = '0;
    preEn = 1'b0; preAddr = '0; preData = '0;
    test_reset();
    test_fetch();
    test_priority();
    test_half_store();
    test_io_store();
    test_clear();
    test_rdy_stall();
    test_reset_mid_read();
    @(negedge clk);
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
